// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the set/reset flag controller.
package sr_ctrl_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_NUM_FLAGS = 8;
   localparam int CNT_MAX       = 255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_e;

endpackage

// File: rtl/sr_flag_controller_if.sv
// Requester command bus: per-requester valid, set/clear masks and one-hot ready.
interface sr_flag_controller_if
   import sr_ctrl_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int NUM_FLAGS = DEF_NUM_FLAGS
) ();

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*NUM_FLAGS-1:0] req_set;
   logic [NUM_REQ*NUM_FLAGS-1:0] req_clr;
   logic [NUM_REQ-1:0]           req_ready;

   modport master (output req_valid, output req_set, output req_clr, input req_ready);
   modport slave  (input req_valid, input req_set, input req_clr, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, wraps, first requester high wins.
module rr_arbiter #(
   parameter int  N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic found;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            grant[(int'(ptr) + k) % N] = 1'b1;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_flag_controller.sv
// Arbitrated set/reset flag bank: capture on grant, apply one edge later, with
// conflict tracking and a one-cycle lockout after a global clear.
module sr_flag_controller
   import sr_ctrl_pkg::*;
#(
   parameter int  NUM_REQ   = DEF_NUM_REQ,
   parameter int  NUM_FLAGS = DEF_NUM_FLAGS,
   localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   sr_flag_controller_if.slave  req,
   input  logic                 clr_all,
   input  logic                 err_clr,
   output logic [NUM_FLAGS-1:0] flags,
   output logic                 conflict_err,
   output logic [7:0]           conflict_cnt,
   output logic [IDW-1:0]       last_id,
   output logic                 busy
);

   state_e                 state_q, state_d;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [NUM_FLAGS-1:0]   cmd_set_q, cmd_set_d;
   logic [NUM_FLAGS-1:0]   cmd_clr_q, cmd_clr_d;
   logic [IDW-1:0]         cmd_id_q, cmd_id_d;
   logic [NUM_FLAGS-1:0]   flags_q, flags_d;
   logic                   err_q, err_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [IDW-1:0]         last_id_q, last_id_d;

   logic [NUM_REQ-1:0]     grant;
   logic [NUM_REQ-1:0]     ready;
   logic [IDW-1:0]         win_id;
   logic                   accept;
   logic                   apply;
   logic                   conflict;
   logic [7:0]             cnt_base;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req   (req.req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   // State register.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: every control and data register is reset; a stale held command must never apply.
      if (reset) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         cmd_set_q <= '0;
         cmd_clr_q <= '0;
         cmd_id_q  <= '0;
         flags_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         last_id_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         cmd_set_q <= cmd_set_d;
         cmd_clr_q <= cmd_clr_d;
         cmd_id_q  <= cmd_id_d;
         flags_q   <= flags_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         last_id_q <= last_id_d;
      end
   end

   // Next-state logic.
   always_comb begin
      if (clr_all)                state_d = FLUSH;
      else if (state_q == FLUSH)  state_d = IDLE;
      else if (accept)            state_d = ACTIVE;
      else                        state_d = IDLE;
   end

   // Outputs: grants are suppressed during reset, clear and the lockout cycle.
   always_comb begin
      ready = (reset || clr_all || state_q == FLUSH) ? '0 : grant;
      busy  = (state_q != IDLE);
   end

   assign req.req_ready = ready;
   assign accept        = |(req.req_valid & ready);

   always_comb begin
      win_id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) win_id = IDW'(i);
      end
   end

   // Datapath: apply held command, capture the next one, track conflicts.
   always_comb begin
      apply     = (state_q == ACTIVE) && !clr_all;
      conflict  = apply && |(cmd_set_q & cmd_clr_q);
      flags_d   = flags_q;
      last_id_d = last_id_q;
      if (apply) begin
         flags_d   = (flags_q & ~(cmd_set_q ^ cmd_clr_q)) | (cmd_set_q & ~cmd_clr_q);
         last_id_d = cmd_id_q;
      end
      if (clr_all) flags_d = '0;

      cmd_set_d = '0;
      cmd_clr_d = '0;
      cmd_id_d  = '0;
      rr_ptr_d  = rr_ptr_q;
      if (accept) begin
         cmd_set_d = req.req_set[win_id*NUM_FLAGS +: NUM_FLAGS];
         cmd_clr_d = req.req_clr[win_id*NUM_FLAGS +: NUM_FLAGS];
         cmd_id_d  = win_id;
         rr_ptr_d  = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end

      // A same-edge conflict wins over err_clr, restarting the count at 1.
      cnt_base = err_clr ? 8'd0 : cnt_q;
      err_d    = err_clr ? 1'b0 : err_q;
      cnt_d    = cnt_base;
      if (conflict) begin
         err_d = 1'b1;
         cnt_d = (cnt_base == 8'(CNT_MAX)) ? cnt_base : cnt_base + 8'd1;
      end
   end

   assign flags        = flags_q;
   assign conflict_err = err_q;
   assign conflict_cnt = cnt_q;
   assign last_id      = last_id_q;

endmodule

// File: tb/tb_sr_flag_controller.sv
// Directed and random checks of sr_flag_controller against a queue-based reference model.
module tb_sr_flag_controller;

   localparam int NR = 4;
   localparam int NF = 8;

   typedef struct {
      logic [NF-1:0] set;
      logic [NF-1:0] clr;
      int            id;
   } cmd_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          clr_all;
   logic          err_clr;
   logic [NF-1:0] flags;
   logic          conflict_err;
   logic [7:0]    conflict_cnt;
   logic [1:0]    last_id;
   logic          busy;

   int tests = 0;
   int fails = 0;

   // Reference model: commands wait one edge in a queue, then apply bit by bit.
   cmd_t          pend[$];
   logic [NF-1:0] m_flags;
   bit            m_err;
   int            m_cnt;
   int            m_last;
   int            m_ptr;
   bit            m_lock;

   sr_flag_controller_if #(.NUM_REQ(NR), .NUM_FLAGS(NF)) bus ();

   sr_flag_controller #(.NUM_REQ(NR), .NUM_FLAGS(NF)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (bus),
      .clr_all      (clr_all),
      .err_clr      (err_clr),
      .flags        (flags),
      .conflict_err (conflict_err),
      .conflict_cnt (conflict_cnt),
      .last_id      (last_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_set   = '0;
      bus.req_clr   = '0;
      clr_all       = 1'b0;
      err_clr       = 1'b0;
   endtask

   task automatic set_cmd(input int i, input logic [NF-1:0] s, input logic [NF-1:0] c);
      bus.req_valid[i]       = 1'b1;
      bus.req_set[i*NF +: NF] = s;
      bus.req_clr[i*NF +: NF] = c;
   endtask

   task automatic model_reset();
      pend.delete();
      m_flags = '0;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_last  = 0;
      m_ptr   = 0;
      m_lock  = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " flags"}, 32'(flags), 32'(m_flags));
      check({tag, " err"},   32'(conflict_err), 32'(m_err));
      check({tag, " cnt"},   32'(conflict_cnt), 32'(m_cnt));
      check({tag, " last"},  32'(last_id), 32'(m_last));
      check({tag, " busy"},  32'(busy), 32'(m_lock || pend.size() != 0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      model_reset();
      #1;
      check("rst ready", 32'(bus.req_ready), 32'd0);
      check_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock cycle; inputs are already driven, called at a falling edge.
   task automatic step(input string tag);
      int            win;
      logic [NR-1:0] exp_ready;
      cmd_t          c;
      bit            conf;
      #1;
      win = -1;
      if (!clr_all && !m_lock) begin
         for (int k = 0; k < NR; k++) begin
            if (win < 0 && bus.req_valid[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
         end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      check({tag, " ready"}, 32'(bus.req_ready), 32'(exp_ready));
      @(posedge clk);
      if (err_clr) begin
         m_err = 1'b0;
         m_cnt = 0;
      end
      if (clr_all) begin
         m_flags = '0;
         pend.delete();
         m_lock = 1'b1;
      end else begin
         m_lock = 1'b0;
         if (pend.size() > 0) begin
            c    = pend.pop_front();
            conf = 1'b0;
            for (int b = 0; b < NF; b++) begin
               if (c.set[b] && !c.clr[b]) m_flags[b] = 1'b1;
               else if (!c.set[b] && c.clr[b]) m_flags[b] = 1'b0;
               if (c.set[b] && c.clr[b]) conf = 1'b1;
            end
            m_last = c.id;
            if (conf) begin
               m_err = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         if (win >= 0) begin
            c.set = bus.req_set[win*NF +: NF];
            c.clr = bus.req_clr[win*NF +: NF];
            c.id  = win;
            pend.push_back(c);
            m_ptr = (win + 1) % NR;
         end
      end
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   initial begin
      // Single command: accept on edge 1, visible on edge 2.
      do_reset();
      set_cmd(0, 8'h0F, 8'h00);
      step("r34 acc");
      check("r34 flags before apply", 32'(flags), 32'h00);
      clear_inputs();
      step("r34 app");
      check("r34 flags", 32'(flags), 32'h0F);
      check("r34 last_id", 32'(last_id), 32'd0);

      // All requesters valid: strict rotation, one grant per cycle.
      do_reset();
      for (int i = 0; i < NR; i++) set_cmd(i, 8'(1 << i), 8'h00);
      for (int k = 0; k < 8; k++) begin
         #1;
         check("r35 order", 32'(bus.req_ready), 32'(1 << (k % NR)));
         check("r35 onehot", 32'($countones(bus.req_ready)), 32'd1);
         step("r35");
      end
      clear_inputs();
      step("r35 drain");

      // Conflicting command and counter saturation.
      do_reset();
      set_cmd(0, 8'h81, 8'h01);
      step("r36 acc");
      clear_inputs();
      step("r36 app");
      check("r36 flags", 32'(flags), 32'h80);
      check("r36 err", 32'(conflict_err), 32'd1);
      check("r36 cnt1", 32'(conflict_cnt), 32'd1);
      set_cmd(0, 8'h81, 8'h01);
      for (int k = 0; k < 300; k++) step("r36 sat");
      clear_inputs();
      step("r36 drain");
      check("r36 cnt sat", 32'(conflict_cnt), 32'd255);

      // Global clear right after accept: command dropped, two cycles without grant.
      do_reset();
      set_cmd(0, 8'hFF, 8'h00);
      step("r37 acc");
      clear_inputs();
      clr_all = 1'b1;
      set_cmd(1, 8'h0F, 8'h00);
      step("r37 clr");
      check("r37 flags", 32'(flags), 32'h00);
      check("r37 busy flush", 32'(busy), 32'd1);
      clr_all = 1'b0;
      #1;
      check("r37 ready flush", 32'(bus.req_ready), 32'd0);
      step("r37 flush");
      check("r37 flags after", 32'(flags), 32'h00);
      check("r37 busy idle", 32'(busy), 32'd0);
      clear_inputs();
      step("r37 idle");

      // err_clr coinciding with a conflicting apply.
      do_reset();
      set_cmd(2, 8'h03, 8'h02);
      for (int k = 0; k < 6; k++) step("r38 build");
      check("r38 cnt5", 32'(conflict_cnt), 32'd5);
      clear_inputs();
      err_clr = 1'b1;
      step("r38 clr");
      check("r38 err", 32'(conflict_err), 32'd1);
      check("r38 cnt", 32'(conflict_cnt), 32'd1);
      clear_inputs();
      step("r38 idle");

      // Asynchronous reset while a command is held.
      do_reset();
      set_cmd(0, 8'h0F, 8'h00);
      step("r39 a");
      clear_inputs();
      step("r39 b");
      set_cmd(1, 8'hF0, 8'h00);
      step("r39 c");
      clear_inputs();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("r39 flags async", 32'(flags), 32'h00);
      check("r39 busy async", 32'(busy), 32'd0);
      check("r39 ready async", 32'(bus.req_ready), 32'd0);
      check("r39 last async", 32'(last_id), 32'd0);
      @(posedge clk);
      #1;
      check("r39 flags edge", 32'(flags), 32'h00);
      @(negedge clk);
      reset = 1'b0;
      step("r39 after");
      check("r39 flags after", 32'(flags), 32'h00);

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 250; k++) begin
         bus.req_valid = NR'($urandom);
         bus.req_set   = (NR*NF)'({$urandom, $urandom});
         bus.req_clr   = (NR*NF)'({$urandom, $urandom}) & (NR*NF)'({$urandom, $urandom});
         clr_all       = ($urandom_range(0, 9) == 0);
         err_clr       = ($urandom_range(0, 7) == 0);
         step("rand");
      end
      clear_inputs();
      step("rand drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sr_flag_controller.md
SR_FLAG_CONTROLLER -- requirements
Module: sr_flag_controller

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the flag bank.
REQ-002 Parameter NUM_FLAGS, default 8: number of set/reset flags in the bank.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester command valid.
REQ-006 req_set  in  NUM_REQ*NUM_FLAGS  per-requester set mask; requester i occupies bits [i*NUM_FLAGS +: NUM_FLAGS].
REQ-007 req_clr  in  NUM_REQ*NUM_FLAGS  per-requester clear mask; same packing as req_set.
REQ-008 req_ready  out  NUM_REQ  one-hot grant; a command is accepted on an edge where req_valid[i] && req_ready[i].
REQ-009 clr_all  in  1  global flag clear and pipeline flush.
REQ-010 err_clr  in  1  clears conflict_err and conflict_cnt.
REQ-011 flags  out  NUM_FLAGS  registered flag bank.
REQ-012 conflict_err  out  1  sticky: some applied command had set and clear on the same bit.
REQ-013 conflict_cnt  out  8  count of conflicting commands, saturating at 255.
REQ-014 last_id  out  clog2(NUM_REQ)  index of the requester whose command was most recently applied.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 Arbitration shall be round-robin: search starts at rr_ptr and wraps; the first requester with req_valid high wins.
REQ-017 req_ready shall be zero in state FLUSH and in any cycle where clr_all is high; otherwise it is one-hot on the winner, or all zero if no requester is valid.
REQ-018 On accept, the winner's masks and index shall be captured into the command register, and rr_ptr shall become winner+1 mod NUM_REQ; rr_ptr is unchanged when nothing is accepted.
REQ-019 The FSM shall have states IDLE (no command held), ACTIVE (command held) and FLUSH (one-cycle post-clear lockout).
REQ-020 Transitions: IDLE/ACTIVE -> ACTIVE on accept; ACTIVE -> IDLE with no accept; any state -> FLUSH when clr_all is sampled high; FLUSH -> IDLE unconditionally.
REQ-021 In ACTIVE, the held command shall be applied at the next edge, bit by bit: set&!clr -> 1; !set&clr -> 0; neither -> hold; both -> hold, and the command counts as a conflict.
REQ-022 Latency shall be 2 edges from accept to flags update; throughput shall be one command per cycle, because apply and capture occur on the same edge.
REQ-023 last_id shall update on the same edge the command is applied.
REQ-024 A conflicting command shall set conflict_err and increment conflict_cnt by exactly 1, regardless of how many bits conflict; conflict_cnt shall saturate at 255.
REQ-025 err_clr shall zero conflict_err and conflict_cnt; if a conflict is applied on the same edge, the result shall be conflict_err=1, conflict_cnt=1.
REQ-026 clr_all sampled high shall zero flags, discard any held command without applying it, and leave conflict state and last_id unchanged.
REQ-027 Precedence shall be: reset > clr_all > command apply.
REQ-028 flags shall never be X or Z: no input combination produces an unknown value.

Reset
REQ-029 Asserting reset shall immediately set flags=0, state=IDLE, rr_ptr=0, command register=0, conflict_err=0, conflict_cnt=0, last_id=0.
REQ-030 Outputs during reset shall be req_ready=0 and busy=0; the first grant is possible in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-operation shall drop any held command, with no partial flag update.

Structure
REQ-032 Package sr_ctrl_pkg shall hold the state enum (IDLE, ACTIVE, FLUSH), the NUM_REQ and NUM_FLAGS defaults, and the CNT_MAX=255 constant.
REQ-033 Arbitration shall live in sub-module rr_arbiter (inputs req, ptr; output one-hot grant); all state and the flag bank shall stay in the top module.

Verification
REQ-034 Reset, then requester 0 set=0x0F, clr=0x00 -> accepted on edge 1, flags=0x0F after edge 2, last_id=0.
REQ-035 All 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; exactly one req_ready high per cycle.
REQ-036 Command set=0x81, clr=0x01 with flags=0x00 -> flags=0x80, conflict_err=1, conflict_cnt=1; 300 such commands -> conflict_cnt=255.
REQ-037 Accept set=0xFF, then assert clr_all the next cycle -> flags=0x00, command not applied, busy high for the FLUSH cycle, req_ready=0 for 2 cycles.
REQ-038 err_clr on the same edge as a conflicting apply, with conflict_cnt=5 -> conflict_err=1, conflict_cnt=1.
REQ-039 Assert reset asynchronously while in ACTIVE (mid-clock) -> outputs zero immediately, with no flags update on the next edge.
